barrett_for_17: RTL and testbench

- Pipelined Barrett modular reducer. Computes a 9-bit unsigned operand modulo the fixed prime 17; also outputs the quotient.
- Datapath primitive for GF(17) arithmetic. Reduces raw products and sums, which are always below 512, to canonical residues 0..16.
- Streaming valid-qualified interface: one operand accepted per cycle, no backpressure.

---
 rtl/barrett_for_17.sv | 87 ++++++++
 tb/tb_barrett_for_17.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/barrett_for_17.sv
// Two-stage Barrett reducer for p=17: din_a -> (din_a mod 17, din_a / 17).
// Define BARRETT_OUTREG_EN to register the correction stage (latency 2); otherwise latency 1.
module barrett_for_17 #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 5,
  parameter int MU    = 60,
  parameter int SHIFT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  din_a,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout_r,
  output logic [OUT_W-1:0] dout_q
);

  localparam int PROD_W = IN_W + 6;
  localparam int R_W    = OUT_W + 1;
  // MU is realised as 2^6 - 2^k with no multiplier; k is derived from MU.
  localparam int MU_LO  = $clog2(64 - MU);

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] prod;
  logic [OUT_W-1:0]  q_est_d;
  logic [IN_W-1:0]   q_times_17;
  logic [R_W-1:0]    r_est_d;

  assign a_ext      = PROD_W'(din_a);
  assign prod       = (a_ext << 6) - (a_ext << MU_LO);
  assign q_est_d    = OUT_W'(prod >> SHIFT);
  assign q_times_17 = (IN_W'(q_est_d) << 4) + IN_W'(q_est_d);
  // q_est undershoots by at most one, so the difference always fits in 0..33.
  assign r_est_d    = R_W'(din_a - q_times_17);

  logic             valid_s1_q;
  logic [OUT_W-1:0] q_s1_q;
  logic [R_W-1:0]   r_s1_q;

  // Data registers load every cycle; only the valid bit qualifies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s1_q <= 1'b0;
      q_s1_q     <= '0;
      r_s1_q     <= '0;
    end else begin
      valid_s1_q <= in_valid;
      q_s1_q     <= q_est_d;
      r_s1_q     <= r_est_d;
    end
  end

  logic             r_ge;
  logic [OUT_W-1:0] r_corr;
  logic [OUT_W-1:0] q_corr;

  assign r_ge   = (r_s1_q >= R_W'(17));
  assign r_corr = r_ge ? OUT_W'(r_s1_q - R_W'(17)) : OUT_W'(r_s1_q);
  assign q_corr = r_ge ? (q_s1_q + OUT_W'(1)) : q_s1_q;

`ifdef BARRETT_OUTREG_EN
  logic             valid_s2_q;
  logic [OUT_W-1:0] r_s2_q;
  logic [OUT_W-1:0] q_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s2_q <= 1'b0;
      r_s2_q     <= '0;
      q_s2_q     <= '0;
    end else begin
      valid_s2_q <= valid_s1_q;
      r_s2_q     <= r_corr;
      q_s2_q     <= q_corr;
    end
  end

  assign out_valid = valid_s2_q;
  assign dout_r    = r_s2_q;
  assign dout_q    = q_s2_q;
`else
  assign out_valid = valid_s1_q;
  assign dout_r    = r_corr;
  assign dout_q    = q_corr;
`endif

endmodule

// File: tb/tb_barrett_for_17.sv
// Directed table plus stream checks for barrett_for_17; latency follows BARRETT_OUTREG_EN.
module tb_barrett_for_17;

`ifdef BARRETT_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [8:0] din_a;
  logic       out_valid;
  logic [4:0] dout_r;
  logic [4:0] dout_q;

  barrett_for_17 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .din_a    (din_a),
    .out_valid(out_valid),
    .dout_r   (dout_r),
    .dout_q   (dout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] a;
    logic [4:0] r;
    logic [4:0] q;
  } vec_t;

  typedef struct {
    logic [8:0] a;
    logic [4:0] r;
    logic [4:0] q;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_beats = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Every output beat is matched in order against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("beat a=%0d r=%0d q=%0d lat=%0d", e.a, dout_r, dout_q, cyc - e.cyc);
        check("dout_r", dout_r, e.r);
        check("dout_q", dout_q, e.q);
        check("latency", cyc - e.cyc, LAT);
      end
    end
  end

  task automatic send(input logic v, input logic [8:0] a, input logic [4:0] r,
                      input logic [4:0] q);
    exp_t e;
    in_valid = v;
    din_a    = a;
    if (v) begin
      e.a = a; e.r = r; e.q = q; e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_timeout_left", exp_q.size(), 0);
  endtask

  vec_t vecs[14];

  initial begin
    int sent;
    int beats0;
    int a;

    vecs[0]  = '{a: 9'd0,   r: 5'd0,  q: 5'd0};
    vecs[1]  = '{a: 9'd16,  r: 5'd16, q: 5'd0};
    vecs[2]  = '{a: 9'd17,  r: 5'd0,  q: 5'd1};
    vecs[3]  = '{a: 9'd510, r: 5'd0,  q: 5'd30};
    vecs[4]  = '{a: 9'd511, r: 5'd1,  q: 5'd30};
    vecs[5]  = '{a: 9'd288, r: 5'd16, q: 5'd16};
    vecs[6]  = '{a: 9'd33,  r: 5'd16, q: 5'd1};
    vecs[7]  = '{a: 9'd34,  r: 5'd0,  q: 5'd2};
    vecs[8]  = '{a: 9'd100, r: 5'd15, q: 5'd5};
    vecs[9]  = '{a: 9'd255, r: 5'd0,  q: 5'd15};
    vecs[10] = '{a: 9'd256, r: 5'd1,  q: 5'd15};
    vecs[11] = '{a: 9'd493, r: 5'd0,  q: 5'd29};
    vecs[12] = '{a: 9'd494, r: 5'd1,  q: 5'd29};
    vecs[13] = '{a: 9'd1,   r: 5'd1,  q: 5'd0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    din_a    = '0;
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_dout_r", dout_r, 0);
    check("reset_dout_q", dout_q, 0);
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, back to back.
    for (int i = 0; i < 14; i++) send(1'b1, vecs[i].a, vecs[i].r, vecs[i].q);
    drain();

    // Identity sweep 0..16.
    for (int i = 0; i <= 16; i++) send(1'b1, 9'(i), 5'(i), 5'd0);
    drain();

    // Reset with operands in flight: outputs clear at once, flushed data never appears.
    send(1'b1, 9'd511, 5'd1, 5'd30);
    send(1'b1, 9'd100, 5'd15, 5'd5);
    in_valid = 1'b0;
    #1;
    check("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_dout_r", dout_r, 0);
    check("async_reset_dout_q", dout_q, 0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_out_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Exhaustive stream with pseudo-random gaps.
    sent   = 0;
    beats0 = n_beats;
    a      = 0;
    while (a < 512) begin
      if ($urandom_range(0, 3) != 0) begin
        send(1'b1, 9'(a), 5'(a % 17), 5'(a / 17));
        sent++;
        a++;
      end else begin
        send(1'b0, 9'($urandom_range(0, 511)), 5'd0, 5'd0);
      end
    end
    drain();
    check("stream_beat_count", n_beats - beats0, sent);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
